dma_priority_arbiter: RTL

- Upstream neighbour of the DMA timing-control FSM.
- Synchronizes the four external DREQ lines and applies DREQ sense polarity, the mask register and software requests.
- Arbitrates with fixed or rotating priority and presents exactly one one-hot VALID_DREQn to the timing FSM.
- Holds the winning channel for the whole service, drives DACK with programmable polarity, and updates rotating priority when service ends.

---
 rtl/dma_priority_arbiter_pkg.sv | 23 ++
 rtl/dma_priority_arbiter_if.sv | 33 +++
 rtl/dma_priority_encoder.sv | 31 +++
 rtl/dma_priority_arbiter.sv | 134 +++++++++++++
 4 files changed

// File: rtl/dma_priority_arbiter_pkg.sv
// Shared types and constants for the DMA request arbiter and its neighbours.
package DmaPackage;

    localparam int NCH = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_SERVE,
        ARB_DONE
    } arb_state_e;

    // Bit positions inside the 8237A-style command register.
    localparam int CMD_DISABLE   = 2;
    localparam int CMD_ROTATE    = 4;
    localparam int CMD_DREQ_LOW  = 6;
    localparam int CMD_DACK_HIGH = 7;

    function automatic logic [NCH-1:0] chOneHot(input logic [1:0] ch);
        return NCH'(1) << ch;
    endfunction

endpackage

// File: rtl/dma_priority_arbiter_if.sv
// Request/acknowledge bundle between the channel pins, the register file,
// the timing FSM and the arbiter.
interface dma_priority_arbiter_if;
    import DmaPackage::*;

    logic [NCH-1:0] DREQ;
    logic [7:0]     commandReg;
    logic [NCH-1:0] maskReg;
    logic [NCH-1:0] requestReg;
    logic           IDLE_CYCLE;
    logic           validDACK;
    logic           eop_n;
    logic           HLDA;
    logic [NCH-1:0] VALID_DREQ;
    logic [NCH-1:0] DACK;
    logic [1:0]     activeCh;
    logic           reqPending;

    // Environment side: drives pins, registers and timing-FSM status.
    modport master (
        output DREQ, commandReg, maskReg, requestReg,
        output IDLE_CYCLE, validDACK, eop_n, HLDA,
        input  VALID_DREQ, DACK, activeCh, reqPending
    );

    // Arbiter side.
    modport slave (
        input  DREQ, commandReg, maskReg, requestReg,
        input  IDLE_CYCLE, validDACK, eop_n, HLDA,
        output VALID_DREQ, DACK, activeCh, reqPending
    );

endinterface

// File: rtl/dma_priority_encoder.sv
// Rotating-start priority search: the first requesting channel at or after
// the start point wins. Fixed mode simply starts the search at channel 0.
module dma_priority_encoder
    import DmaPackage::*;
(
    input  logic [NCH-1:0] eff,
    input  logic [1:0]     pointer,
    input  logic           rotate,
    output logic [1:0]     winner,
    output logic           valid
);

    logic [1:0] start;
    logic [1:0] idx;

    // Walk from lowest priority to highest so the highest hit is kept last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        start  = rotate ? pointer : 2'd0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = start + 2'(i);
            if (eff[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DREQ conditioning, channel arbitration and DACK generation in front of
// the DMA timing-control FSM. One channel is held from grant to end of
// service; the rotating pointer advances only on a normal completion.
module dma_priority_arbiter
    import DmaPackage::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    dma_priority_arbiter_if.slave bus
);

    logic [SYNC_STAGES-1:0][NCH-1:0] syncQ;
    logic [NCH-1:0] sreq;
    logic [NCH-1:0] eff;
    logic [1:0]     winner;
    logic           winValid;
    logic           hldaQ;
    logic           hldaFall;
    logic           rotate;

    arb_state_e     state, nextState;
    logic [NCH-1:0] validQ, validNext;
    logic [1:0]     chQ, chNext;
    logic [1:0]     ptrQ, ptrNext;
    logic           abortQ, abortNext;
    logic           eopPendQ, eopPendNext;
    logic [NCH-1:0] dackQ, dackNext;

    logic unusedCmd;
    assign unusedCmd = ^{bus.commandReg[5], bus.commandReg[3], bus.commandReg[1:0]};

    // DREQ polarity is folded in before the synchronizer chain.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            syncQ <= '0;
        end else begin
            syncQ[0] <= bus.DREQ ^ {NCH{bus.commandReg[CMD_DREQ_LOW]}};
            for (int i = 1; i < SYNC_STAGES; i++) syncQ[i] <= syncQ[i-1];
        end
    end

    assign sreq     = syncQ[SYNC_STAGES-1];
    assign eff      = bus.commandReg[CMD_DISABLE] ? '0 : ((sreq & ~bus.maskReg) | bus.requestReg);
    assign rotate   = bus.commandReg[CMD_ROTATE];
    assign hldaFall = hldaQ & ~bus.HLDA;

    dma_priority_encoder uEnc (
        .eff     (eff),
        .pointer (ptrQ),
        .rotate  (rotate),
        .winner  (winner),
        .valid   (winValid)
    );

    // State, grant and pointer registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= ARB_IDLE;
            validQ   <= '0;
            chQ      <= '0;
            ptrQ     <= '0;
            abortQ   <= 1'b0;
            eopPendQ <= 1'b0;
            hldaQ    <= 1'b0;
            dackQ    <= '0;
        end else begin
            state    <= nextState;
            validQ   <= validNext;
            chQ      <= chNext;
            ptrQ     <= ptrNext;
            abortQ   <= abortNext;
            eopPendQ <= eopPendNext;
            hldaQ    <= bus.HLDA;
            dackQ    <= bus.commandReg[CMD_DACK_HIGH] ? dackNext : ~dackNext;
        end
    end

    // Next-state logic; an EOP seen together with validDACK is remembered so
    // the service lasts exactly one cycle.
    always_comb begin
        nextState   = state;
        validNext   = validQ;
        chNext      = chQ;
        ptrNext     = ptrQ;
        abortNext   = abortQ;
        eopPendNext = eopPendQ;
        case (state)
            ARB_IDLE: begin
                abortNext   = 1'b0;
                eopPendNext = 1'b0;
                if (bus.IDLE_CYCLE && winValid) begin
                    chNext    = winner;
                    validNext = chOneHot(winner);
                    nextState = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (hldaFall) begin
                    abortNext = 1'b1;
                    nextState = ARB_DONE;
                end else if (bus.validDACK) begin
                    eopPendNext = ~bus.eop_n;
                    nextState   = ARB_SERVE;
                end else if (!eff[chQ]) begin
                    validNext = '0;
                    nextState = ARB_IDLE;
                end
            end
            ARB_SERVE: begin
                if (hldaFall) begin
                    abortNext = 1'b1;
                    nextState = ARB_DONE;
                end else if (!bus.eop_n || bus.IDLE_CYCLE || eopPendQ) begin
                    nextState = ARB_DONE;
                end
            end
            ARB_DONE: begin
                validNext = '0;
                if (rotate && !abortQ) ptrNext = chQ + 2'd1;
                nextState = ARB_IDLE;
            end
            default: nextState = ARB_IDLE;
        endcase
        dackNext = (nextState == ARB_SERVE) ? chOneHot(chNext) : '0;
    end

    assign bus.VALID_DREQ = validQ;
    assign bus.DACK       = dackQ;
    assign bus.activeCh   = chQ;
    assign bus.reqPending = |eff;

endmodule
